// File: rtl/fir_sched_pkg.sv
// Shared widths, FSM states and coefficient ROM for the
// folded symmetric FIR tap scheduler.
package fir_sched_pkg;

   localparam int NSLOT  = 8;
   localparam int TAP_W  = 9;
   localparam int COEF_W = 8;
   localparam int ACC_W  = 20;
   localparam int PROD_W = TAP_W + COEF_W;
   localparam int SLOT_W = $clog2(NSLOT);

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      DRAIN,
      DONE
   } state_e;

   typedef logic signed [TAP_W-1:0]  tap_t;
   typedef logic signed [COEF_W-1:0] coef_t;
   typedef logic signed [PROD_W-1:0] prod_t;
   typedef logic signed [ACC_W-1:0]  acc_t;
   typedef logic        [SLOT_W-1:0] slot_t;

   typedef struct packed {
      logic clr;
      logic en;
   } mac_ctrl_t;

   // Slots 0..6 are the symmetric pairs, slot 7 the centre tap
   localparam coef_t COEF [0:NSLOT-1] = '{
      -8'sd3,
      -8'sd7,
      8'sd5,
      8'sd18,
      -8'sd12,
      -8'sd40,
      8'sd37,
      8'sd127
   };

   localparam slot_t LAST_SLOT = slot_t'(NSLOT - 1);

   function automatic coef_t coef_of(input slot_t s);
      return COEF[s];
   endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Shared signed multiplier with a product pipeline register
// feeding a full-precision accumulator.
module fir_mac_unit
   import fir_sched_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  mac_ctrl_t ctrl,
   input  tap_t      tap,
   input  coef_t     coef,
   output acc_t      acc
);

   prod_t prod_d, prod_q;
   acc_t  acc_d, acc_q;

   always_comb begin
      prod_d = prod_q;
      acc_d  = acc_q;
      if (ctrl.en) begin
         prod_d = prod_t'(tap) * prod_t'(coef);
      end
      // Clear wins: the product held on the first slot is stale
      if (ctrl.clr) begin
         acc_d = '0;
      end else if (ctrl.en) begin
         acc_d = acc_q + acc_t'(prod_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prod_q <= '0;
         acc_q  <= '0;
      end else begin
         prod_q <= prod_d;
         acc_q  <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/fir_tap_scheduler.sv
// Sequencer for the folded FIR: accepts a sample, shifts the delay
// line, runs eight MAC slots and hands the result downstream.
module fir_tap_scheduler
   import fir_sched_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic                     shift_en,
   input  logic signed [TAP_W-1:0]  tapsum_0,
   input  logic signed [TAP_W-1:0]  tapsum_1,
   input  logic signed [TAP_W-1:0]  tapsum_2,
   input  logic signed [TAP_W-1:0]  tapsum_3,
   input  logic signed [TAP_W-1:0]  tapsum_4,
   input  logic signed [TAP_W-1:0]  tapsum_5,
   input  logic signed [TAP_W-1:0]  tapsum_6,
   input  logic signed [TAP_W-2:0]  tapsum_7,
   output logic        [ACC_W-1:0]  filter_out,
   output logic                     out_valid,
   input  logic                     out_ready
);

   state_e    state_d, state_q;
   slot_t     slot_d, slot_q;
   mac_ctrl_t mac_ctrl;
   tap_t      tap_sel;
   coef_t     coef_sel;
   acc_t      acc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         slot_q  <= '0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      slot_d       = slot_q;
      in_ready     = 1'b0;
      shift_en     = 1'b0;
      out_valid    = 1'b0;
      mac_ctrl.clr = 1'b0;
      mac_ctrl.en  = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               shift_en = ~reset;
               slot_d   = '0;
               state_d  = MAC;
            end
         end
         MAC: begin
            mac_ctrl.en  = 1'b1;
            mac_ctrl.clr = (slot_q == '0);
            slot_d       = slot_q + 1'b1;
            if (slot_q == LAST_SLOT) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Folds in the slot 7 product still in the pipeline
            mac_ctrl.en = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_comb begin
      tap_sel = '0;
      unique case (slot_q)
         3'd0: tap_sel = tapsum_0;
         3'd1: tap_sel = tapsum_1;
         3'd2: tap_sel = tapsum_2;
         3'd3: tap_sel = tapsum_3;
         3'd4: tap_sel = tapsum_4;
         3'd5: tap_sel = tapsum_5;
         3'd6: tap_sel = tapsum_6;
         3'd7: tap_sel = {tapsum_7[TAP_W-2], tapsum_7};
      endcase
   end

   assign coef_sel = coef_of(slot_q);

   fir_mac_unit u_mac (
      .clk   (clk),
      .reset (reset),
      .ctrl  (mac_ctrl),
      .tap   (tap_sel),
      .coef  (coef_sel),
      .acc   (acc)
   );

   assign filter_out = acc;

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Scoreboard bench for fir_tap_scheduler: results, latency,
// hold behaviour under back-pressure and mid-flight reset.
module tb_fir_tap_scheduler;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic              shift_en;
   logic signed [8:0] tapsum_0, tapsum_1, tapsum_2, tapsum_3;
   logic signed [8:0] tapsum_4, tapsum_5, tapsum_6;
   logic signed [7:0] tapsum_7;
   logic [19:0]       filter_out;
   logic              out_valid;
   logic              out_ready;

   fir_tap_scheduler dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .shift_en   (shift_en),
      .tapsum_0   (tapsum_0),
      .tapsum_1   (tapsum_1),
      .tapsum_2   (tapsum_2),
      .tapsum_3   (tapsum_3),
      .tapsum_4   (tapsum_4),
      .tapsum_5   (tapsum_5),
      .tapsum_6   (tapsum_6),
      .tapsum_7   (tapsum_7),
      .filter_out (filter_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int hs_cyc   = -1;
   int shift_cnt = 0;
   int shift_exp = 0;
   int exp_q[$];
   int acc_t_q[$];
   int coef[8] = '{-3, -7, 5, 18, -12, -40, 37, 127};
   logic        prev_valid = 1'b0;
   logic [19:0] prev_out   = '0;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int model(input int t[8]);
      int s = 0;
      for (int i = 0; i < 8; i++) s += t[i] * coef[i];
      return s;
   endfunction

   task automatic drive_taps(input int t[8]);
      tapsum_0 = t[0][8:0];
      tapsum_1 = t[1][8:0];
      tapsum_2 = t[2][8:0];
      tapsum_3 = t[3][8:0];
      tapsum_4 = t[4][8:0];
      tapsum_5 = t[5][8:0];
      tapsum_6 = t[6][8:0];
      tapsum_7 = t[7][7:0];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (shift_en) begin
         shift_cnt++;
         acc_t_q.push_back(cyc);
      end
      if (out_valid && !prev_valid) begin
         if (acc_t_q.size() == 0) check("spurious_valid", 1, 0);
         else check("latency", cyc - acc_t_q.pop_front(), 10);
      end
      if (out_valid) begin
         check("busy_in_ready", int'(in_ready), 0);
         check("busy_shift_en", int'(shift_en), 0);
         if (prev_valid) check("hold_stable", int'(filter_out), int'(prev_out));
         if (out_ready) begin
            hs_cyc = cyc;
            if (exp_q.size() == 0) check("unexpected_result", 1, 0);
            else check("filter_out", int'($signed(filter_out)), exp_q.pop_front());
         end
      end
      prev_valid = out_valid;
      prev_out   = filter_out;
   end

   // Presents garbage on the tap sums during T0 so a scheduler that
   // samples too early is caught; real tap sums appear from T1.
   task automatic accept(input int t[8], input bit keep_valid);
      int g[8];
      int n;
      foreach (g[i]) g[i] = int'($urandom_range(0, 255)) - 128;
      drive_taps(g);
      in_valid = 1'b1;
      exp_q.push_back(model(t));
      shift_exp++;
      n = 0;
      @(negedge clk);
      while (!shift_en && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!shift_en) check("accept_timeout", 0, 1);
      tick();
      drive_taps(t);
      in_valid = keep_valid;
   endtask

   task automatic finish_result(input int stall);
      int n;
      n = 0;
      out_ready = (stall == 0);
      while (!out_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) check("result_timeout", 0, 1);
      if (stall > 0) begin
         repeat (stall - 1) @(negedge clk);
         tick();
         out_ready = 1'b1;
      end
      tick();
   endtask

   task automatic rand_taps(output int t[8]);
      for (int i = 0; i < 7; i++) t[i] = int'($urandom_range(0, 511)) - 256;
      t[7] = int'($urandom_range(0, 255)) - 128;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t[8];
      reset     = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      t = '{0, 0, 0, 0, 0, 0, 0, 0};
      drive_taps(t);
      repeat (2) begin
         @(negedge clk);
         check("reset_shift_en", int'(shift_en), 0);
      end
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("idle_in_ready", int'(in_ready), 1);
         check("idle_out_valid", int'(out_valid), 0);
         check("idle_shift_en", int'(shift_en), 0);
         check("idle_filter_out", int'($signed(filter_out)), 0);
      end
      tick();

      t = '{1, 0, 0, 0, 0, 0, 0, 0};
      accept(t, 1'b0);
      finish_result(0);
      t = '{1, 1, 1, 1, 1, 1, 1, 1};
      accept(t, 1'b0);
      finish_result(0);
      t = '{0, 0, 0, 0, 0, 0, 0, -128};
      accept(t, 1'b0);
      finish_result(0);
      t = '{-256, -256, -256, -256, -256, -256, -256, -128};
      accept(t, 1'b0);
      finish_result(0);
      t = '{255, -256, 255, 255, -256, -256, 255, 127};
      accept(t, 1'b0);
      finish_result(0);

      // Back-pressure with in_valid held across the stall
      rand_taps(t);
      out_ready = 1'b0;
      accept(t, 1'b1);
      begin
         int n = 0;
         while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
         end
         if (!out_valid) check("stall_timeout", 0, 1);
      end
      repeat (4) @(negedge clk);
      tick();
      out_ready = 1'b1;
      exp_q.push_back(model(t));
      shift_exp++;
      tick();
      @(negedge clk);
      check("restart_shift_en", int'(shift_en), 1);
      check("restart_cycle", cyc - hs_cyc, 1);
      tick();
      in_valid = 1'b0;
      finish_result(0);

      // Reset at T5 drops the in-flight sample
      rand_taps(t);
      accept(t, 1'b0);
      repeat (4) tick();
      reset = 1'b1;
      exp_q.delete();
      acc_t_q.delete();
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_filter_out", int'($signed(filter_out)), 0);
      repeat (15) @(negedge clk);
      tick();
      rand_taps(t);
      accept(t, 1'b0);
      finish_result(0);

      for (int k = 0; k < 4; k++) begin
         rand_taps(t);
         accept(t, 1'b0);
         finish_result(int'($urandom_range(0, 3)));
      end

      repeat (3) tick();
      check("shift_count", shift_cnt, shift_exp);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
